// File: rtl/uart_rx_cfg_if.sv
// Receive-side result bus of uart_rx_cfg: received word, frame strobes and busy.
interface uart_rx_cfg_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stop_err;
    logic                  brk;
    logic                  busy;

    modport master (
        output P_DATA, data_valid, par_err, stop_err, brk, busy
    );

    modport slave (
        input P_DATA, data_valid, par_err, stop_err, brk, busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised RX line, 3-point majority vote per bit,
// optional parity, one/two stop bits, start-glitch rejection and break detection.
module uart_rx_cfg #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    uart_rx_cfg_if.master         rx_out
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int BCW = 4;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    rx_s;
    logic [PRESCALE_W-1:0]   edge_cnt;
    logic [PRESCALE_W-1:0]   p_lat;
    logic [PRESCALE_W-1:0]   smp_lo, smp_mid, smp_hi, last_edge;
    logic [BCW-1:0]          bit_cnt;
    logic                    par_en_lat, par_typ_lat, stop2_lat;
    logic [2:0]              smp;
    logic                    vote, ferr_fin, zero_fin;
    logic                    ferr, perr, all_zero, brk_hold;
    logic [DATA_WIDTH-1:0]   shreg, p_data_q;
    logic                    data_valid_q, par_err_q, stop_err_q, brk_q, busy_q;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign smp_mid   = p_lat >> 1;
    assign smp_lo    = smp_mid - PRESCALE_W'(1);
    assign smp_hi    = smp_mid + PRESCALE_W'(1);
    assign last_edge = p_lat - PRESCALE_W'(1);

    assign rx_out.P_DATA     = p_data_q;
    assign rx_out.data_valid = data_valid_q;
    assign rx_out.par_err    = par_err_q;
    assign rx_out.stop_err   = stop_err_q;
    assign rx_out.brk        = brk_q;
    assign rx_out.busy       = busy_q;

    // Bring the asynchronous line into the clock domain; preset to idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
    end

    // Majority of the three samples, plus error/break flags as they would stand
    // including the bit currently being completed.
    always_comb begin
        vote     = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
        ferr_fin = ferr | ~vote;
        zero_fin = all_zero & ~vote;
    end

    // Receive FSM: bit timing, sampling, shifting, error tracking and frame-end strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            p_lat        <= '0;
            par_en_lat   <= 1'b0;
            par_typ_lat  <= 1'b0;
            stop2_lat    <= 1'b0;
            smp          <= '0;
            ferr         <= 1'b0;
            perr         <= 1'b0;
            all_zero     <= 1'b0;
            brk_hold     <= 1'b0;
            shreg        <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            brk_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            brk_q        <= 1'b0;

            if (state != IDLE) begin
                if (edge_cnt == smp_lo)  smp[0] <= rx_s;
                if (edge_cnt == smp_mid) smp[1] <= rx_s;
                if (edge_cnt == smp_hi)  smp[2] <= rx_s;
            end

            if (state == IDLE) begin
                if (brk_hold) begin
                    // After a break the line must stay high for a whole bit time;
                    // edge_cnt counts consecutive high cycles and restarts on any low.
                    if (!rx_s) begin
                        edge_cnt <= '0;
                    end else if (edge_cnt == last_edge) begin
                        edge_cnt <= '0;
                        brk_hold <= 1'b0;
                    end else begin
                        edge_cnt <= edge_cnt + PRESCALE_W'(1);
                    end
                end else if (!rx_s) begin
                    state       <= START;
                    busy_q      <= 1'b1;
                    edge_cnt    <= PRESCALE_W'(1);
                    bit_cnt     <= '0;
                    p_lat       <= Prescale;
                    par_en_lat  <= PAR_EN;
                    par_typ_lat <= PAR_TYP;
                    stop2_lat   <= STOP2;
                    ferr        <= 1'b0;
                    perr        <= 1'b0;
                    all_zero    <= 1'b1;
                end
            end else if (edge_cnt != last_edge) begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end else begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + BCW'(1);
                case (state)
                    START: begin
                        if (vote) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg    <= {vote, shreg[DATA_WIDTH-1:1]};
                        all_zero <= zero_fin;
                        if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_lat ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        perr     <= (^shreg ^ par_typ_lat) != vote;
                        all_zero <= zero_fin;
                        bit_cnt  <= '0;
                        state    <= STOP;
                    end
                    STOP: begin
                        if (bit_cnt == {{(BCW-1){1'b0}}, stop2_lat}) begin
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                            bit_cnt <= '0;
                            if (zero_fin) begin
                                brk_q    <= 1'b1;
                                brk_hold <= 1'b1;
                            end else if (ferr_fin) begin
                                stop_err_q <= 1'b1;
                            end else if (perr) begin
                                par_err_q <= 1'b1;
                            end else begin
                                data_valid_q <= 1'b1;
                                p_data_q     <= shreg;
                            end
                        end else begin
                            ferr     <= ferr_fin;
                            all_zero <= zero_fin;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
